// File: rtl/verificador_colisao.sv
// Collision checker for a two-player grid game: per-player occupancy bitmaps,
// shot evaluation with a one-shot done pulse, and remaining-cell counters.
module verificador_colisao #(
  parameter int unsigned GRID_N    = 8,
  parameter int unsigned MAX_PECAS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       limpa,
  input  logic       wr_en,
  input  logic       wr_player,
  input  logic [3:0] wr_x,
  input  logic [3:0] wr_y,
  input  logic       ready,
  input  logic       alvo,
  input  logic [3:0] coord_tiroX,
  input  logic [3:0] coord_tiroY,
  output logic       acertou_tiro,
  output logic       done,
  output logic       busy,
  output logic [3:0] qtd_P1,
  output logic [3:0] qtd_P2
);

  typedef enum logic [1:0] {IDLE, CHECK, RESULT, WAIT_LOW} state_t;

  localparam int unsigned CELLS    = GRID_N * GRID_N;
  localparam int unsigned IDX_W    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [4:0]  GRID_LIM = 5'(GRID_N);
  localparam logic [3:0]  MAX_LIM  = 4'(MAX_PECAS);

  state_t                state_q, state_d;
  logic [1:0][CELLS-1:0] mapa_q, mapa_d;
  logic [1:0][3:0]       qtd_q, qtd_d;
  logic                  ready_q, ready_d;
  logic                  alvo_q, alvo_d;
  logic [3:0]            tiro_x_q, tiro_x_d;
  logic [3:0]            tiro_y_q, tiro_y_d;
  logic                  acertou_q, acertou_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic                  start_c;
  logic                  tiro_ok_c;
  logic                  hit_c;
  logic                  wr_ok_c;
  logic [IDX_W-1:0]      tiro_idx_c;
  logic [IDX_W-1:0]      wr_idx_c;

  function automatic logic in_grid(input logic [3:0] c);
    return {1'b0, c} < GRID_LIM;
  endfunction

  function automatic logic [IDX_W-1:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
    return IDX_W'(32'(y) * GRID_N + 32'(x));
  endfunction

  // Next-state, bitmap and counter logic; limpa overrides everything below it.
  always_comb begin
    state_d   = state_q;
    mapa_d    = mapa_q;
    qtd_d     = qtd_q;
    ready_d   = ready;
    alvo_d    = alvo_q;
    tiro_x_d  = tiro_x_q;
    tiro_y_d  = tiro_y_q;
    acertou_d = acertou_q;
    done_d    = 1'b0;

    start_c    = (state_q == IDLE) && ready && !ready_q;
    tiro_idx_c = cell_idx(tiro_x_q, tiro_y_q);
    tiro_ok_c  = in_grid(tiro_x_q) && in_grid(tiro_y_q);
    hit_c      = tiro_ok_c && mapa_q[alvo_q][tiro_idx_c];
    wr_idx_c   = cell_idx(wr_x, wr_y);
    wr_ok_c    = wr_en && !start_c
                 && ((state_q == IDLE) || (state_q == WAIT_LOW))
                 && in_grid(wr_x) && in_grid(wr_y)
                 && !mapa_q[wr_player][wr_idx_c]
                 && (qtd_q[wr_player] < MAX_LIM);

    case (state_q)
      IDLE: begin
        if (start_c) begin
          alvo_d   = alvo;
          tiro_x_d = coord_tiroX;
          tiro_y_d = coord_tiroY;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (hit_c) begin
          mapa_d[alvo_q][tiro_idx_c] = 1'b0;
          if (qtd_q[alvo_q] != 4'd0) qtd_d[alvo_q] = qtd_q[alvo_q] - 4'd1;
        end
        acertou_d = hit_c;
        done_d    = 1'b1;
        state_d   = RESULT;
      end
      RESULT:   state_d = WAIT_LOW;
      WAIT_LOW: if (!ready) state_d = IDLE;
    endcase

    if (wr_ok_c) begin
      mapa_d[wr_player][wr_idx_c] = 1'b1;
      qtd_d[wr_player]            = qtd_q[wr_player] + 4'd1;
    end

    if (limpa) begin
      state_d   = IDLE;
      mapa_d    = '0;
      qtd_d     = '0;
      acertou_d = 1'b0;
      done_d    = 1'b0;
    end

    busy_d = (state_d == CHECK) || (state_d == RESULT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      mapa_q    <= '0;
      qtd_q     <= '0;
      ready_q   <= 1'b0;
      alvo_q    <= 1'b0;
      tiro_x_q  <= '0;
      tiro_y_q  <= '0;
      acertou_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mapa_q    <= mapa_d;
      qtd_q     <= qtd_d;
      ready_q   <= ready_d;
      alvo_q    <= alvo_d;
      tiro_x_q  <= tiro_x_d;
      tiro_y_q  <= tiro_y_d;
      acertou_q <= acertou_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign acertou_tiro = acertou_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign qtd_P1       = qtd_q[0];
  assign qtd_P2       = qtd_q[1];

endmodule

// File: tb/tb_verificador_colisao.sv
// Randomized scoreboard bench for verificador_colisao against a board-level
// reference model (2-D occupancy arrays and per-player counters).
module tb_verificador_colisao;

  localparam int GRID = 8;
  localparam int MAXP = 8;

  logic       clk = 1'b0;
  logic       reset, limpa, wr_en, wr_player, ready, alvo;
  logic [3:0] wr_x, wr_y, coord_tiroX, coord_tiroY;
  logic       acertou_tiro, done, busy;
  logic [3:0] qtd_P1, qtd_P2;

  verificador_colisao #(.GRID_N(GRID), .MAX_PECAS(MAXP)) dut (
    .clk(clk), .reset(reset), .limpa(limpa), .wr_en(wr_en), .wr_player(wr_player),
    .wr_x(wr_x), .wr_y(wr_y), .ready(ready), .alvo(alvo),
    .coord_tiroX(coord_tiroX), .coord_tiroY(coord_tiroY),
    .acertou_tiro(acertou_tiro), .done(done), .busy(busy),
    .qtd_P1(qtd_P1), .qtd_P2(qtd_P2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hit;
    int q1;
    int q2;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  // Reference board: occ[player][x][y], remaining counts, last reported result.
  bit occ [2][16][16];
  int cnt [2];
  int last_hit;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void m_clear();
    for (int p = 0; p < 2; p++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) occ[p][x][y] = 1'b0;
    cnt[0] = 0;
    cnt[1] = 0;
    last_hit = 0;
  endfunction

  function automatic void m_place(input int p, input int x, input int y);
    if (x < GRID && y < GRID && !occ[p][x][y] && cnt[p] < MAXP) begin
      occ[p][x][y] = 1'b1;
      cnt[p]++;
    end
  endfunction

  function automatic int m_shot(input int p, input int x, input int y);
    int h;
    h = (x < GRID && y < GRID && occ[p][x][y]) ? 1 : 0;
    if (h == 1) begin
      occ[p][x][y] = 1'b0;
      cnt[p]--;
    end
    last_hit = h;
    return h;
  endfunction

  // Monitor: samples just after each rising edge, pops one expectation per done.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (done === 1'b1) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_latency", cyc, e.cyc);
          chk("acertou_tiro", int'(acertou_tiro), e.hit);
          chk("qtd_P1_at_done", int'(qtd_P1), e.q1);
          chk("qtd_P2_at_done", int'(qtd_P2), e.q2);
        end
      end
    end
  end

  task automatic place(input int p, input int x, input int y);
    @(negedge clk);
    wr_en = 1'b1; wr_player = p[0]; wr_x = 4'(x); wr_y = 4'(y);
    m_place(p, x, y);
    @(negedge clk);
    wr_en = 1'b0;
    chk("qtd_P1_after_wr", int'(qtd_P1), cnt[0]);
    chk("qtd_P2_after_wr", int'(qtd_P2), cnt[1]);
  endtask

  task automatic do_limpa();
    @(negedge clk);
    limpa = 1'b1;
    m_clear();
    @(negedge clk);
    limpa = 1'b0;
    chk("qtd_P1_after_limpa", int'(qtd_P1), 0);
    chk("qtd_P2_after_limpa", int'(qtd_P2), 0);
    chk("acertou_after_limpa", int'(acertou_tiro), 0);
  endtask

  // Raise ready with a shot; optional write at the start cycle and during CHECK.
  task automatic shot(input int p, input int x, input int y, input bit wr_same,
                      input bit wr_busy, input int hold);
    exp_t e;
    int   seen;
    @(negedge clk);
    ready = 1'b1; alvo = p[0]; coord_tiroX = 4'(x); coord_tiroY = 4'(y);
    if (wr_same) begin
      wr_en = 1'b1; wr_player = 1'($urandom_range(0, 1));
      wr_x = 4'($urandom_range(0, GRID - 1)); wr_y = 4'($urandom_range(0, GRID - 1));
    end
    e.hit = m_shot(p, x, y);
    e.q1  = cnt[0];
    e.q2  = cnt[1];
    e.cyc = cyc + 2;
    sb.push_back(e);
    seen = done_cnt;
    @(negedge clk);
    wr_en = 1'b0;
    chk("busy_in_check", int'(busy), 1);
    if (wr_busy) begin
      wr_en = 1'b1; wr_player = 1'($urandom_range(0, 1));
      wr_x = 4'($urandom_range(0, GRID - 1)); wr_y = 4'($urandom_range(0, GRID - 1));
    end
    @(negedge clk);
    wr_en = 1'b0;
    for (int i = 0; i < 8 && done_cnt == seen; i++) @(negedge clk);
    if (done_cnt == seen) begin
      chk("done_timeout", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    repeat (hold) @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    chk("acertou_hold", int'(acertou_tiro), last_hit);
    chk("busy_idle", int'(busy), 0);
  endtask

  // Start a shot, then abort it in CHECK with limpa (use_reset=0) or reset.
  task automatic abort_shot(input int p, input int x, input int y, input bit use_reset);
    @(negedge clk);
    ready = 1'b1; alvo = p[0]; coord_tiroX = 4'(x); coord_tiroY = 4'(y);
    @(negedge clk);
    if (use_reset) begin
      reset = 1'b0; ready = 1'b0;
    end else begin
      limpa = 1'b1;
    end
    m_clear();
    @(negedge clk);
    reset = 1'b1; limpa = 1'b0;
    repeat (3) @(negedge clk);
    ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_qtd_P1", int'(qtd_P1), 0);
    chk("abort_qtd_P2", int'(qtd_P2), 0);
    chk("abort_busy", int'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   op, p, x, y;
    reset = 1'b0; limpa = 1'b0; wr_en = 1'b0; wr_player = 1'b0; wr_x = '0; wr_y = '0;
    ready = 1'b0; alvo = 1'b0; coord_tiroX = '0; coord_tiroY = '0;
    m_clear();
    repeat (3) @(negedge clk);
    chk("rst_acertou", int'(acertou_tiro), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_qtd_P1", int'(qtd_P1), 0);
    chk("rst_qtd_P2", int'(qtd_P2), 0);
    reset = 1'b1;
    @(negedge clk);

    // Basic hit, repeat shot, out-of-range shot.
    place(1, 3, 5);
    shot(1, 3, 5, 1'b0, 1'b0, 1);
    shot(1, 3, 5, 1'b0, 1'b0, 1);
    place(0, 1, 1); place(1, 7, 7); place(1, 0, 2);
    shot(0, 8, 8, 1'b0, 1'b0, 1);
    shot(1, 9, 2, 1'b0, 1'b0, 0);
    shot(1, 7, 7, 1'b0, 1'b1, 2);

    // Capacity: nine distinct P1 cells plus a duplicate, then out-of-range writes.
    do_limpa();
    for (int i = 0; i < 9; i++) place(0, i % GRID, i / GRID);
    place(0, 2, 0);
    place(1, 8, 0); place(1, 0, 15);
    chk("qtd_P1_full", int'(qtd_P1), 8);

    // ready held 20 cycles with a write at the start cycle.
    shot(0, 4, 0, 1'b1, 1'b1, 20);

    // Aborts by limpa and by reset during CHECK.
    place(0, 5, 5); place(1, 6, 6);
    abort_shot(0, 5, 5, 1'b0);
    place(1, 2, 3);
    abort_shot(1, 2, 3, 1'b1);

    // ready already high when reset releases counts as a start.
    place(0, 0, 0);
    @(negedge clk);
    reset = 1'b0; ready = 1'b1; alvo = 1'b0; coord_tiroX = 4'd0; coord_tiroY = 4'd0;
    m_clear();
    @(negedge clk);
    reset = 1'b1;
    e.hit = m_shot(0, 0, 0); e.q1 = cnt[0]; e.q2 = cnt[1]; e.cyc = cyc + 2;
    sb.push_back(e);
    repeat (5) @(negedge clk);
    ready = 1'b0;
    @(negedge clk);

    // Randomized mix of placements, shots and clears.
    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 19));
      p  = int'($urandom_range(0, 1));
      x  = int'($urandom_range(0, 9));
      y  = int'($urandom_range(0, 9));
      if (op < 10) begin
        place(p, x, y);
      end else if (op < 19) begin
        if (op < 15) begin
          x = int'($urandom_range(0, GRID - 1));
          y = int'($urandom_range(0, GRID - 1));
        end
        shot(p, x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)));
      end else begin
        do_limpa();
      end
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
